// File: rtl/calc_key_debounce.sv
// Key/func input conditioning for the calculator core: optional 2-flop sync, one-key lockout
// debounce FSM, func debounce and accepted-press counter. Optional sync: `CALC_KEY_SYNC_EN.
module calc_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] key_raw,
  input  logic       res_raw,
  input  logic [2:0] func_raw,
  output logic       zero,
  output logic       one,
  output logic       two,
  output logic       three,
  output logic       four,
  output logic       five,
  output logic       six,
  output logic       seven,
  output logic       eight,
  output logic       nine,
  output logic       get_res,
  output logic [2:0] func,
  output logic [7:0] press_count
);

  localparam int         NUM_KEYS = 11;
  localparam logic [7:0] DEB      = 8'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  logic [NUM_KEYS-1:0] keys;
  logic [NUM_KEYS-1:0] keys_s;
  logic [2:0]          func_s;

  assign keys = {res_raw, key_raw};

`ifdef CALC_KEY_SYNC_EN
  logic [NUM_KEYS+2:0] sync1_q, sync1_d;
  logic [NUM_KEYS+2:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = {func_raw, keys};
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign {func_s, keys_s} = sync2_q;
`else
  assign keys_s = keys;
  assign func_s = func_raw;
`endif

  // Counters stop at the threshold so a long-held input can never roll over and retrigger.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= DEB) ? v : v + 8'd1;
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          cand_q, cand_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] out_q, out_d;
  logic [7:0]          press_count_q, press_count_d;
  logic [3:0]          low_idx;

  // Lowest set index wins: digit 0 has top priority, result key the lowest.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys_s[i]) low_idx = 4'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    press_count_d = press_count_q;
    case (state_q)
      IDLE: begin
        if (|keys_s) begin
          cand_d  = low_idx;
          cnt_d   = '0;
          state_d = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (keys_s[cand_q]) begin
          cnt_d = sat_inc(cnt_q);
          if (cnt_d == DEB) begin
            state_d       = HELD;
            press_count_d = press_count_q + 8'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HELD: begin
        if (keys_s == '0) begin
          cnt_d   = '0;
          state_d = DEB_REL;
        end
      end
      DEB_REL: begin
        if (|keys_s) begin
          state_d = HELD;
        end else begin
          cnt_d = sat_inc(cnt_q);
          if (cnt_d == DEB) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    out_d = '0;
    if (state_d == HELD || state_d == DEB_REL) out_d = NUM_KEYS'(1) << cand_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cand_q        <= '0;
      cnt_q         <= '0;
      out_q         <= '0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      out_q         <= out_d;
      press_count_q <= press_count_d;
    end
  end

  logic [2:0] func_q, func_d;
  logic [2:0] func_cand_q, func_cand_d;
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    func_d      = func_q;
    func_cand_d = func_cand_q;
    fcnt_d      = fcnt_q;
    if (func_s != func_cand_q) begin
      func_cand_d = func_s;
      fcnt_d      = '0;
    end else if (func_s != func_q) begin
      fcnt_d = sat_inc(fcnt_q);
      if (fcnt_d == DEB) func_d = func_cand_q;
    end else begin
      fcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q      <= '0;
      func_cand_q <= '0;
      fcnt_q      <= '0;
    end else begin
      func_q      <= func_d;
      func_cand_q <= func_cand_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign {get_res, nine, eight, seven, six, five, four, three, two, one, zero} = out_q;
  assign func        = func_q;
  assign press_count = press_count_q;

endmodule
